// File: rtl/accel_sample_sequencer.sv
// Periodic accelerometer sampler: on each tick it reads six bytes (X/Y/Z lo/hi) over a
// shared byte-read bus and commits all three axes together, aborting a read that stalls.
module accel_sample_sequencer #(
  parameter int unsigned SAMPLE_DIV  = 500000,
  parameter int unsigned ACK_TIMEOUT = 1023,
  parameter logic [5:0]  BASE_ADDR   = 6'h32
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        enable,
  output logic        rd_req,
  output logic [5:0]  rd_addr,
  input  logic        rd_ack,
  input  logic [7:0]  rd_data,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic [15:0] accel_z,
  output logic        sample_valid,
  output logic        busy,
  output logic        timeout_err,
  output logic        overrun,
  output logic [7:0]  err_count
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT_ACK, S_GAP, S_COMMIT} state_t;

  localparam logic [23:0] TICK_LAST = 24'(SAMPLE_DIV - 1);
  localparam logic [15:0] TO_LAST   = 16'(ACK_TIMEOUT - 1);
  localparam logic [2:0]  LAST_IDX  = 3'd5;

  state_t           state;
  state_t           state_nxt;
  logic [23:0]      tick_cnt;
  logic             tick;
  logic [2:0]       idx;
  logic [15:0]      to_cnt;
  logic [5:0][7:0]  shadow;
  logic             in_req;
  logic             ack_hit;
  logic             to_hit;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign tick    = enable && (tick_cnt == TICK_LAST);
  assign in_req  = (state == S_REQ) || (state == S_WAIT_ACK);
  assign ack_hit = in_req && rd_ack;
  // An ack in the final allowed cycle still wins over the timeout.
  assign to_hit  = in_req && !rd_ack && (to_cnt == TO_LAST);

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) state <= S_IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:             if (tick) state_nxt = S_REQ;
      S_REQ, S_WAIT_ACK: begin
        if (rd_ack)      state_nxt = S_GAP;
        else if (to_hit) state_nxt = S_IDLE;
        else             state_nxt = S_WAIT_ACK;
      end
      S_GAP:              state_nxt = (idx == LAST_IDX) ? S_COMMIT : S_REQ;
      S_COMMIT:           state_nxt = S_IDLE;
      default:            state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rd_req  = in_req;
    busy    = (state != S_IDLE);
    rd_addr = in_req ? BASE_ADDR + {3'b000, idx} : 6'd0;
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      tick_cnt     <= '0;
      idx          <= '0;
      to_cnt       <= '0;
      shadow       <= '0;
      accel_x      <= '0;
      accel_y      <= '0;
      accel_z      <= '0;
      sample_valid <= 1'b0;
      timeout_err  <= 1'b0;
      overrun      <= 1'b0;
      err_count    <= '0;
    end else begin
      tick_cnt <= (!enable || tick_cnt == TICK_LAST) ? 24'd0 : tick_cnt + 24'd1;

      if (state == S_IDLE && tick)                 idx <= '0;
      else if (state == S_GAP && idx != LAST_IDX)  idx <= idx + 3'd1;

      to_cnt <= in_req ? to_cnt + 16'd1 : 16'd0;

      if (ack_hit)     shadow[idx] <= rd_data;
      else if (to_hit) shadow      <= '0;

      // All three axes move in the same cycle so readers never see a torn sample.
      sample_valid <= (state == S_COMMIT);
      if (state == S_COMMIT) begin
        accel_x <= {shadow[1], shadow[0]};
        accel_y <= {shadow[3], shadow[2]};
        accel_z <= {shadow[5], shadow[4]};
      end

      if (to_hit) err_count <= sat_inc(err_count);

      if (!enable)     timeout_err <= 1'b0;
      else if (to_hit) timeout_err <= 1'b1;

      if (!enable)            overrun <= 1'b0;
      else if (tick && busy)  overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_accel_sample_sequencer.sv
// Bench for accel_sample_sequencer: schedule-based reference model checked every cycle,
// a table of directed sample sequences, and hand-written timeout/overrun/reset/saturation runs.
module tb_accel_sample_sequencer;

  localparam int         DIV  = 16;
  localparam int         TMO  = 8;
  localparam logic [5:0] BASE = 6'h32;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic        enable;
  logic        rd_req;
  logic [5:0]  rd_addr;
  logic        rd_ack;
  logic [7:0]  rd_data;
  logic [15:0] accel_x, accel_y, accel_z;
  logic        sample_valid, busy, timeout_err, overrun;
  logic [7:0]  err_count;

  always #5 clk_clk = ~clk_clk;

  accel_sample_sequencer #(.SAMPLE_DIV(DIV), .ACK_TIMEOUT(TMO), .BASE_ADDR(BASE)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .enable(enable),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z),
    .sample_valid(sample_valid), .busy(busy), .timeout_err(timeout_err),
    .overrun(overrun), .err_count(err_count)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: one sequence record (start cycle, ack delay, dropped byte, bytes).
  int          m_cnt = 0;
  bit          m_act = 0;
  int          m_start = 0, m_last = 0, m_d = 0, m_k = 7, m_err = 0;
  logic [47:0] m_b = '0;
  logic [15:0] m_x = '0, m_y = '0, m_z = '0;
  bit          m_sv = 0, m_to = 0, m_ovr = 0;

  int          mode = 1;
  int          dir_d = 2, dir_k = 7;
  logic [47:0] dir_b = '0;

  bit prev_req = 0, req_rise = 0, req_fall = 0, late_ack = 0;
  int age = 0;

  typedef struct {
    int          d;
    logic [47:0] b;
    logic [15:0] ex, ey, ez;
    int          lat;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic start_seq(input int c);
    m_act   = 1;
    m_start = c;
    if (mode == 1) begin
      m_d = dir_d; m_k = dir_k; m_b = dir_b;
    end else begin
      m_d = int'($urandom_range(0, 4));
      m_k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : 7;
      m_b = 48'({$urandom(), $urandom()});
    end
    m_last = (m_k < 6) ? c + m_k * (2 + m_d) + TMO - 1 : c + 6 * (2 + m_d);
  endtask

  task automatic model_edge(input bit en_e, input bit rst_e);
    int e;
    bit busy_e, tick_e, to_ev, ovr_ev;
    e = cyc - 1;
    if (!rst_e) begin
      m_cnt = 0; m_act = 0; m_x = '0; m_y = '0; m_z = '0;
      m_sv = 0; m_to = 0; m_ovr = 0; m_err = 0;
    end else begin
      busy_e = m_act && e >= m_start && e <= m_last;
      tick_e = en_e && (m_cnt == DIV - 1);
      m_cnt  = en_e ? (m_cnt + 1) % DIV : 0;
      m_sv = 0; to_ev = 0; ovr_ev = 0;
      if (busy_e && e == m_last) begin
        m_act = 0;
        if (m_k < 6) begin
          to_ev = 1;
          if (m_err < 255) m_err++;
        end else begin
          m_x = m_b[15:0]; m_y = m_b[31:16]; m_z = m_b[47:32]; m_sv = 1;
        end
      end
      if (tick_e) begin
        if (busy_e) ovr_ev = 1;
        else        start_seq(cyc);
      end
      if (!en_e) begin
        m_to = 0; m_ovr = 0;
      end else begin
        if (to_ev)  m_to = 1;
        if (ovr_ev) m_ovr = 1;
      end
    end
  endtask

  task automatic check_model();
    int off, p, idx;
    bit bx, rq;
    bx = m_act && cyc >= m_start && cyc <= m_last;
    rq = 0; idx = 0;
    if (bx) begin
      off = cyc - m_start;
      p   = 2 + m_d;
      if (m_k < 6 && off >= m_k * p) begin
        rq = 1; idx = m_k;
      end else if (off < 6 * p && off % p <= m_d) begin
        rq = 1; idx = off / p;
      end
    end
    chk("busy",         32'(busy),         32'(bx));
    chk("rd_req",       32'(rd_req),       32'(rq));
    chk("rd_addr",      32'(rd_addr),      rq ? 32'(int'(BASE) + idx) : 32'd0);
    chk("sample_valid", 32'(sample_valid), 32'(m_sv));
    chk("accel_x",      32'(accel_x),      32'(m_x));
    chk("accel_y",      32'(accel_y),      32'(m_y));
    chk("accel_z",      32'(accel_z),      32'(m_z));
    chk("timeout_err",  32'(timeout_err),  32'(m_to));
    chk("overrun",      32'(overrun),      32'(m_ovr));
    chk("err_count",    32'(err_count),    32'(m_err));
  endtask

  // Bus master model: acks m_d cycles after each request rise, never acks the dropped
  // byte, and sprinkles stray acks while no request is pending.
  task automatic drive_bus();
    int i;
    if (rd_req === 1'b1) begin
      age = prev_req ? age + 1 : 0;
      i   = int'(rd_addr) - int'(BASE);
      if (age == m_d && i != m_k && i >= 0 && i < 6) begin
        rd_ack = 1'b1; rd_data = m_b[i*8 +: 8];
      end else begin
        rd_ack = 1'b0; rd_data = 8'($urandom());
      end
    end else begin
      age     = 0;
      rd_ack  = late_ack || ($urandom_range(0, 3) == 0);
      rd_data = 8'($urandom());
    end
    prev_req = (rd_req === 1'b1);
  endtask

  task automatic step();
    bit en_e, rst_e, pr;
    en_e = enable;
    rst_e = reset_reset_n;
    @(posedge clk_clk);
    #1;
    cyc++;
    model_edge(en_e, rst_e);
    check_model();
    pr = prev_req;
    req_rise = (rd_req === 1'b1) && !pr;
    req_fall = (rd_req === 1'b0) && pr;
    drive_bus();
  endtask

  task automatic do_reset();
    reset_reset_n = 1'b0;
    enable = 1'b0;
    step();
    step();
    reset_reset_n = 1'b1;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      if (sample_valid === 1'b1) ok = 1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok, addr_ok, found;
    int t0, at, n_rise, rise_c, fall_c, n_to, n_req;

    vecs[0] = '{d: 2, b: 48'h8001_ABCD_1234, ex: 16'h1234, ey: 16'hABCD, ez: 16'h8001, lat: 26};
    vecs[1] = '{d: 0, b: 48'h7FFF_8000_FFFF, ex: 16'hFFFF, ey: 16'h8000, ez: 16'h7FFF, lat: 14};
    vecs[2] = '{d: 7, b: 48'h0000_0102_A55A, ex: 16'hA55A, ey: 16'h0102, ez: 16'h0000, lat: 56};
    vecs[3] = '{d: 1, b: 48'hC3C3_0FF0_F00F, ex: 16'hF00F, ey: 16'h0FF0, ez: 16'hC3C3, lat: 20};

    reset_reset_n = 1'b0;
    enable = 1'b0;
    rd_ack = 1'b0;
    rd_data = 8'h00;

    for (int v = 0; v < 4; v++) begin
      do_reset();
      mode = 1; dir_d = vecs[v].d; dir_k = 7; dir_b = vecs[v].b;
      enable = 1'b1;
      t0 = cyc + DIV - 1;
      n_rise = 0; addr_ok = 1; ok = 0; at = -1;
      for (int i = 0; i < 200 && !ok; i++) begin
        step();
        if (req_rise) begin
          if (int'(rd_addr) != int'(BASE) + n_rise) addr_ok = 0;
          n_rise++;
        end
        if (sample_valid === 1'b1) begin ok = 1; at = cyc; end
      end
      enable = 1'b0;
      chk("vec_valid_seen", 32'(ok), 32'd1);
      chk("vec_latency",    32'(at - t0), 32'(vecs[v].lat));
      chk("vec_accel_x",    32'(accel_x), 32'(vecs[v].ex));
      chk("vec_accel_y",    32'(accel_y), 32'(vecs[v].ey));
      chk("vec_accel_z",    32'(accel_z), 32'(vecs[v].ez));
      chk("vec_req_count",  32'(n_rise), 32'd6);
      chk("vec_addr_seq",   32'(addr_ok), 32'd1);
    end

    // Timeout on byte 3, then recovery with a full sequence.
    do_reset();
    mode = 1; dir_d = 2; dir_k = 7; dir_b = 48'h8001_ABCD_1234;
    enable = 1'b1;
    wait_valid(200, ok);
    chk("to_prior_valid", 32'(ok), 32'd1);
    dir_k = 3;
    rise_c = -1; fall_c = -1;
    for (int i = 0; i < 400 && timeout_err !== 1'b1; i++) begin
      step();
      if (req_rise && int'(rd_addr) == int'(BASE) + 3) rise_c = cyc;
      if (req_fall && rise_c >= 0 && fall_c < 0) fall_c = cyc;
    end
    chk("to_flag",      32'(timeout_err), 32'd1);
    chk("to_req_width", 32'(fall_c - rise_c), 32'(TMO));
    chk("to_err_count", 32'(err_count), 32'd1);
    chk("to_keep_x",    32'(accel_x), 32'h1234);
    chk("to_keep_y",    32'(accel_y), 32'hABCD);
    chk("to_keep_z",    32'(accel_z), 32'h8001);
    dir_k = 7; dir_b = 48'h0003_0002_0001;
    wait_valid(200, ok);
    chk("to_recover_valid", 32'(ok), 32'd1);
    chk("to_recover_x", 32'(accel_x), 32'h0001);
    chk("to_recover_y", 32'(accel_y), 32'h0002);
    chk("to_recover_z", 32'(accel_z), 32'h0003);
    chk("to_overrun_set", 32'(overrun), 32'd1);
    enable = 1'b0;
    step();
    chk("clr_timeout_err", 32'(timeout_err), 32'd0);
    chk("clr_overrun",     32'(overrun), 32'd0);
    chk("clr_keeps_count", 32'(err_count), 32'd1);

    // Overrun with slow acks, then a one-cycle enable drop clears it.
    dir_d = 3;
    enable = 1'b1;
    wait_valid(200, ok);
    chk("ovr_valid1", 32'(ok), 32'd1);
    wait_valid(200, ok);
    chk("ovr_valid2", 32'(ok), 32'd1);
    chk("ovr_flag",   32'(overrun), 32'd1);
    enable = 1'b0;
    step();
    chk("ovr_clear",  32'(overrun), 32'd0);

    // Reset in the middle of waiting for byte 2, followed by a stray late ack.
    do_reset();
    dir_d = 4; dir_k = 7; dir_b = 48'h0606_0505_0404;
    enable = 1'b1;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (rd_req === 1'b1 && !req_rise && int'(rd_addr) == int'(BASE) + 2) found = 1;
    end
    chk("rst_wait_found", 32'(found), 32'd1);
    reset_reset_n = 1'b0;
    step();
    reset_reset_n = 1'b1;
    chk("rst_rd_req",  32'(rd_req), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_busy",    32'(busy), 32'd0);
    chk("rst_valid",   32'(sample_valid), 32'd0);
    chk("rst_x",       32'(accel_x), 32'd0);
    chk("rst_y",       32'(accel_y), 32'd0);
    chk("rst_z",       32'(accel_z), 32'd0);
    chk("rst_to",      32'(timeout_err), 32'd0);
    chk("rst_ovr",     32'(overrun), 32'd0);
    chk("rst_errs",    32'(err_count), 32'd0);
    late_ack = 1;
    for (int i = 0; i < 3; i++) step();
    late_ack = 0;
    chk("late_ack_busy", 32'(busy), 32'd0);
    chk("late_ack_x",    32'(accel_x), 32'd0);

    // Saturate the error counter with repeated byte-0 timeouts.
    dir_k = 0;
    n_to = 0;
    for (int i = 0; i < 305 * DIV; i++) begin
      step();
      if (req_rise) n_to++;
    end
    chk("sat_timeouts", 32'(n_to >= 300), 32'd1);
    chk("sat_count",    32'(err_count), 32'hFF);

    // Enable falls during byte 4: sequence still commits, nothing follows.
    dir_k = 7; dir_d = 2; dir_b = 48'h1111_2222_3333;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (rd_req === 1'b1 && int'(rd_addr) == int'(BASE) + 4) found = 1;
    end
    chk("drop_byte4_found", 32'(found), 32'd1);
    enable = 1'b0;
    wait_valid(100, ok);
    chk("drop_commits", 32'(ok), 32'd1);
    chk("drop_accel_z", 32'(accel_z), 32'h1111);
    n_req = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (rd_req !== 1'b0) n_req++;
    end
    chk("drop_no_req", 32'(n_req), 32'd0);

    // Randomized sequences with occasional enable drops and resets.
    do_reset();
    mode = 0;
    enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (enable && $urandom_range(0, 299) == 0)        enable = 1'b0;
      else if (!enable && $urandom_range(0, 2) == 0)    enable = 1'b1;
      reset_reset_n = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
      step();
    end
    reset_reset_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
